// File: rtl/axis_pkt_fifo_sync.sv
// axis_pkt_fifo_sync
//   Single-clock AXI-Stream FIFO with first-word-fall-through output and a
//   per-beat tlast sideband. With PKT_MODE=1 a packet becomes readable only
//   once its tlast beat is accepted. Errored packets (tuser on tlast) and
//   packets that can never commit (oversize or deadlocked) are discarded by
//   rewinding the write pointer to the commit pointer.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tlast  write beat; s_axis_tuser = error flag on tlast
//   s_axis_tready              registered write ready
//   m_axis_tdata/tlast/tvalid  FWFT read beat; m_axis_tready = read ready
//   level                      occupied words incl. uncommitted and output reg
//   almost_full                level >= ALMOST_FULL_NUM
//   almost_empty               committed words <= ALMOST_EMPTY_NUM
//   drop_cnt                   saturating count of discarded packets
module axis_pkt_fifo_sync #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH_WIDTH      = 10,
  parameter bit          PKT_MODE         = 1'b1,
  parameter int unsigned ALMOST_FULL_NUM  = 1020,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DEPTH_WIDTH:0]  level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  typedef logic [DEPTH_WIDTH:0] ptr_t;
  typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_e;

  localparam ptr_t DEPTH_P = DEPTH[DEPTH_WIDTH:0];
  localparam ptr_t AF_P    = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
  localparam ptr_t AE_P    = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];

  logic [DATA_WIDTH:0] mem [DEPTH];

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   commit_ptr_q, commit_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  state_e state_q, state_d;

  logic                  s_tready_q, s_tready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  ptr_t                  level_q, level_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic wr_acc, mem_we, rd_load, drop_inc;
  ptr_t ov_ext, uncommitted, committed_d;

  always_comb begin
    // Read side: refill the output register whenever it is free or draining.
    rd_load     = (!out_valid_q || m_axis_tready) && (commit_ptr_q != rd_ptr_q);
    out_valid_d = rd_load || (out_valid_q && !m_axis_tready);
    rd_ptr_d    = rd_ptr_q + ptr_t'(rd_load);
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (rd_load) begin
      out_data_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]][DATA_WIDTH-1:0];
      out_last_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]][DATA_WIDTH];
    end

    // Write side
    wr_acc       = s_axis_tvalid && s_tready_q;
    mem_we       = wr_acc && (state_q == ST_ACCEPT);
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    state_d      = state_q;
    drop_inc     = 1'b0;
    if (wr_acc) begin
      if (!PKT_MODE) begin
        wr_ptr_d     = wr_ptr_q + ptr_t'(1);
        commit_ptr_d = wr_ptr_q + ptr_t'(1);
      end else if (state_q == ST_DROP) begin
        if (s_axis_tlast) state_d = ST_ACCEPT;
      end else if (s_axis_tlast && s_axis_tuser) begin
        wr_ptr_d = commit_ptr_q;
        drop_inc = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (s_axis_tlast) commit_ptr_d = wr_ptr_q + ptr_t'(1);
      end
    end

    // The output register counts as a storage slot, so fullness is judged on
    // total occupancy; a packet that can never commit is abandoned here.
    ov_ext      = ptr_t'(out_valid_d);
    uncommitted = wr_ptr_d - commit_ptr_d;
    if (PKT_MODE && state_q == ST_ACCEPT && uncommitted != '0 &&
        (uncommitted == DEPTH_P ||
         ((wr_ptr_d - rd_ptr_d + ov_ext) == DEPTH_P && commit_ptr_d == rd_ptr_d))) begin
      wr_ptr_d = commit_ptr_d;
      state_d  = ST_DROP;
      drop_inc = 1'b1;
    end

    level_d        = wr_ptr_d - rd_ptr_d + ov_ext;
    committed_d    = commit_ptr_d - rd_ptr_d + ov_ext;
    almost_full_d  = level_d >= AF_P;
    almost_empty_d = committed_d <= AE_P;
    s_tready_d     = (state_d == ST_DROP) || (level_d != DEPTH_P);
    drop_cnt_d     = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      state_q        <= ST_ACCEPT;
      s_tready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      level_q        <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      drop_cnt_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      state_q        <= state_d;
      s_tready_q     <= s_tready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      level_q        <= level_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  assign level         = level_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
